// File: rtl/elastic_join_n.sv
// elastic_join_n: N-input elastic join. Each channel is buffered by its own
// DEPTH-entry FIFO. One joined token leaves when every enabled channel holds
// data; every enabled channel then pops its head in the same cycle.

// One channel FIFO: registered storage, no bypass, ready from local state only.
module ejn_lane #(
    parameter int DW    = 32,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1),
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en_i,
    input  logic          flush_i,
    input  logic          vld_i,
    input  logic [DW-1:0] data_i,
    input  logic          pop_i,
    output logic          rdy_o,
    output logic          head_v_o,
    output logic [DW-1:0] head_o,
    output logic [CW-1:0] cnt_o
);
    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          full, push, pop;

    assign full     = (cnt_q == CW'(DEPTH));
    assign head_v_o = (cnt_q != '0);
    assign rdy_o    = en_i && !full;
    assign cnt_o    = cnt_q;

    // A flushing cycle discards any handshake that happens alongside it.
    assign push = vld_i && rdy_o && !flush_i;
    assign pop  = pop_i && en_i && head_v_o && !flush_i;

    // Lane is zero unless it is enabled and actually holds a head entry, so
    // dout reads as zero out of reset and for disabled channels.
    assign head_o = (en_i && head_v_o) ? mem_q[rd_ptr_q] : '0;

    // Next-state for pointers and count; power-of-two DEPTH makes the
    // pointer increment wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Pointer/count state, cleared asynchronously so dout_v drops at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: it is never observed while the count is zero.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= data_i;
    end
endmodule

module elastic_join_n #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_INPUTS = 2,
    parameter int DEPTH      = 2,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] din,
    input  logic [NUM_INPUTS-1:0]            din_v,
    output logic [NUM_INPUTS-1:0]            din_r,
    output logic [NUM_INPUTS*DATA_WIDTH-1:0] dout,
    output logic                             dout_v,
    input  logic                             dout_r,
    input  logic [NUM_INPUTS-1:0]            cfg_enable,
    input  logic                             cfg_flush,
    output logic [NUM_INPUTS*CW-1:0]         occupancy
);
    logic [NUM_INPUTS-1:0] head_v;
    logic                  fire;

    // Join condition: at least one channel enabled and every enabled channel
    // has a head entry. Disabled channels are treated as always satisfied.
    assign dout_v = (|cfg_enable) && (&(~cfg_enable | head_v));
    assign fire   = dout_v && dout_r;

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_lane
        ejn_lane #(
            .DW    (DATA_WIDTH),
            .DEPTH (DEPTH),
            .CW    (CW)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .en_i     (cfg_enable[i]),
            .flush_i  (cfg_flush),
            .vld_i    (din_v[i]),
            .data_i   (din[i*DATA_WIDTH +: DATA_WIDTH]),
            .pop_i    (fire),
            .rdy_o    (din_r[i]),
            .head_v_o (head_v[i]),
            .head_o   (dout[i*DATA_WIDTH +: DATA_WIDTH]),
            .cnt_o    (occupancy[i*CW +: CW])
        );
    end
endmodule

// File: tb/tb_elastic_join_n.sv
module tb_elastic_join_n;
    localparam int DW = 16, NI = 3, DEPTH = 2, CW = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NI*DW-1:0]  din, dout;
    logic [NI-1:0]     din_v, din_r, cfg_enable;
    logic              dout_v, dout_r, cfg_flush;
    logic [NI*CW-1:0]  occupancy;

    elastic_join_n #(.DATA_WIDTH(DW), .NUM_INPUTS(NI), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_v(din_v), .din_r(din_r),
        .dout(dout), .dout_v(dout_v), .dout_r(dout_r), .cfg_enable(cfg_enable),
        .cfg_flush(cfg_flush), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- table-driven vectors ----------------
    typedef struct {
        logic [2:0]  en;
        logic [2:0]  v;
        logic [47:0] d;
        logic        rdy;
        logic        e_dv;
        logic [2:0]  e_r;
        logic [47:0] e_dout;
        logic [5:0]  e_occ;
    } vec_t;

    function automatic vec_t mk(logic [2:0] en, logic [2:0] v, logic [47:0] d, logic rdy,
                                logic e_dv, logic [2:0] e_r, logic [47:0] e_dout, logic [5:0] e_occ);
        vec_t t;
        t.en = en; t.v = v; t.d = d; t.rdy = rdy;
        t.e_dv = e_dv; t.e_r = e_r; t.e_dout = e_dout; t.e_occ = e_occ;
        return t;
    endfunction

    // ---------------- reference model: one queue per channel ----------------
    logic [DW-1:0] mq [NI][$];

    task automatic model_check(input string tag);
        logic          any_en, all_ok;
        logic [NI-1:0] e_r;
        logic [NI*CW-1:0] e_occ;
        logic [NI*DW-1:0] e_dout;
        any_en = 1'b0; all_ok = 1'b1; e_dout = '0;
        for (int i = 0; i < NI; i++) begin
            e_r[i] = cfg_enable[i] && (mq[i].size() < DEPTH);
            e_occ[i*CW +: CW] = CW'(mq[i].size());
            if (cfg_enable[i]) begin
                any_en = 1'b1;
                if (mq[i].size() == 0) all_ok = 1'b0;
                else e_dout[i*DW +: DW] = mq[i][0];
            end
        end
        chk({tag, " din_r"}, 64'(din_r), 64'(e_r));
        chk({tag, " occupancy"}, 64'(occupancy), 64'(e_occ));
        chk({tag, " dout_v"}, 64'(dout_v), 64'(any_en && all_ok));
        if (any_en && all_ok) chk({tag, " dout"}, 64'(dout), 64'(e_dout));
    endtask

    task automatic model_step();
        logic          any_en, all_ok;
        logic [NI-1:0] acc;
        any_en = 1'b0; all_ok = 1'b1;
        for (int i = 0; i < NI; i++) begin
            acc[i] = din_v[i] && cfg_enable[i] && (mq[i].size() < DEPTH);
            if (cfg_enable[i]) begin
                any_en = 1'b1;
                if (mq[i].size() == 0) all_ok = 1'b0;
            end
        end
        if (cfg_flush) begin
            for (int i = 0; i < NI; i++) mq[i].delete();
        end else begin
            for (int i = 0; i < NI; i++) begin
                if (any_en && all_ok && dout_r && cfg_enable[i]) void'(mq[i].pop_front());
                if (acc[i]) mq[i].push_back(din[i*DW +: DW]);
            end
        end
    endtask

    vec_t tbl [11];
    logic [47:0] sb [$];
    logic [47:0] exp_tok;

    initial begin
        rst_n = 1'b0; din = '0; din_v = '0; dout_r = 1'b0;
        cfg_enable = 3'b101; cfg_flush = 1'b0;

        tbl[0]  = mk(3'b111, 3'b111, {16'h33, 16'h22, 16'h11}, 1, 0, 3'b111, '0, 6'b000000);
        tbl[1]  = mk(3'b111, 3'b000, '0, 1, 1, 3'b111, {16'h33, 16'h22, 16'h11}, 6'b010101);
        tbl[2]  = mk(3'b111, 3'b000, '0, 1, 0, 3'b111, '0, 6'b000000);
        tbl[3]  = mk(3'b001, 3'b111, {16'hAA, 16'hBB, 16'h44}, 1, 0, 3'b001, '0, 6'b000000);
        tbl[4]  = mk(3'b001, 3'b000, '0, 1, 1, 3'b001, {16'h0, 16'h0, 16'h44}, 6'b000001);
        tbl[5]  = mk(3'b001, 3'b001, {16'h0, 16'h0, 16'h55}, 1, 0, 3'b001, '0, 6'b000000);
        tbl[6]  = mk(3'b011, 3'b000, '0, 1, 0, 3'b011, '0, 6'b000001);
        tbl[7]  = mk(3'b011, 3'b010, {16'h0, 16'h66, 16'h0}, 1, 0, 3'b011, '0, 6'b000001);
        tbl[8]  = mk(3'b011, 3'b000, '0, 1, 1, 3'b011, {16'h0, 16'h66, 16'h55}, 6'b000101);
        tbl[9]  = mk(3'b111, 3'b000, '0, 1, 0, 3'b111, '0, 6'b000000);
        tbl[10] = mk(3'b000, 3'b111, {16'h1, 16'h2, 16'h3}, 1, 0, 3'b000, '0, 6'b000000);

        // Reset state
        #12;
        chk("reset dout_v", 64'(dout_v), 64'd0);
        chk("reset occupancy", 64'(occupancy), 64'd0);
        chk("reset dout", 64'(dout), 64'd0);
        chk("reset din_r", 64'(din_r), 64'(3'b101));
        tick();
        rst_n = 1'b1;
        tick();

        // Tests 1 and 4: table
        for (int k = 0; k < 11; k++) begin
            cfg_enable = tbl[k].en; din_v = tbl[k].v; din = tbl[k].d; dout_r = tbl[k].rdy;
            @(negedge clk);
            chk($sformatf("tbl%0d dout_v", k), 64'(dout_v), 64'(tbl[k].e_dv));
            chk($sformatf("tbl%0d din_r", k), 64'(din_r), 64'(tbl[k].e_r));
            chk($sformatf("tbl%0d occupancy", k), 64'(occupancy), 64'(tbl[k].e_occ));
            if (tbl[k].e_dv) chk($sformatf("tbl%0d dout", k), 64'(dout), 64'(tbl[k].e_dout));
            tick();
        end

        // Test 2: skewed arrival
        cfg_enable = 3'b111; dout_r = 1'b1; din = {16'hC2, 16'hC1, 16'hC0};
        for (int c = 0; c < 8; c++) begin
            din_v = {c == 5, c == 3, c == 0};
            @(negedge clk);
            chk($sformatf("skew c%0d dout_v", c), 64'(dout_v), 64'(c == 6));
            chk($sformatf("skew c%0d occ0", c), 64'(occupancy[1:0]), 64'((c >= 1 && c <= 6) ? 1 : 0));
            if (c == 6) chk("skew dout", 64'(dout), 64'({16'hC2, 16'hC1, 16'hC0}));
            if (c == 7) chk("skew occ drained", 64'(occupancy), 64'd0);
            tick();
        end

        // Test 3: back-pressure then drain against a scoreboard
        dout_r = 1'b0; din_v = 3'b111;
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < NI; i++) din[i*DW +: DW] = 16'(16'h100 * (i + 1) + c);
            @(negedge clk);
            chk($sformatf("bp c%0d din_r", c), 64'(din_r), 64'(c < 2 ? 3'b111 : 3'b000));
            if (c < 2) sb.push_back(din);
            if (c >= 1) begin
                chk($sformatf("bp c%0d dout_v", c), 64'(dout_v), 64'd1);
                chk($sformatf("bp c%0d dout hold", c), 64'(dout), 64'(sb[0]));
            end
            tick();
        end
        din_v = '0; dout_r = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (sb.size() != 0) begin
                exp_tok = sb.pop_front();
                chk($sformatf("drain %0d dout_v", k), 64'(dout_v), 64'd1);
                chk($sformatf("drain %0d dout", k), 64'(dout), 64'(exp_tok));
            end else begin
                chk("drain empty dout_v", 64'(dout_v), 64'd0);
            end
            tick();
        end

        // Test 5: flush with two tokens buffered
        dout_r = 1'b0; din_v = 3'b111; din = {16'h5, 16'h6, 16'h7};
        tick(); tick();
        din_v = '0; dout_r = 1'b1; cfg_flush = 1'b1;
        @(negedge clk);
        chk("flush pre occupancy", 64'(occupancy), 64'(6'b101010));
        chk("flush pre din_r", 64'(din_r), 64'(3'b000));
        tick();
        cfg_flush = 1'b0;
        @(negedge clk);
        chk("flush post occupancy", 64'(occupancy), 64'd0);
        chk("flush post dout_v", 64'(dout_v), 64'd0);
        tick();

        // Test 6: asynchronous reset while a token is presented
        dout_r = 1'b0; din_v = 3'b111; din = {16'h9, 16'h8, 16'h7};
        tick();
        din_v = '0;
        @(negedge clk);
        chk("rst pre dout_v", 64'(dout_v), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst mid dout_v", 64'(dout_v), 64'd0);
        chk("rst mid occupancy", 64'(occupancy), 64'd0);
        chk("rst mid dout", 64'(dout), 64'd0);
        tick();
        rst_n = 1'b1; cfg_enable = 3'b110;
        @(negedge clk);
        chk("rst post din_r", 64'(din_r), 64'(3'b110));
        chk("rst post dout_v", 64'(dout_v), 64'd0);
        tick();

        // Randomized traffic against the queue model (DUT is empty here)
        for (int i = 0; i < NI; i++) mq[i].delete();
        cfg_enable = 3'b111;
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(15) == 0) cfg_enable = 3'($urandom);
            din_v     = 3'($urandom);
            din       = {16'($urandom), 16'($urandom), 16'($urandom)};
            dout_r    = ($urandom_range(9) < 7);
            cfg_flush = ($urandom_range(49) == 0);
            @(negedge clk);
            model_check($sformatf("rnd%0d", n));
            model_step();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/elastic_join_n.md
Name: elastic_join_n

Overview:
N-input elastic join for the CGRA datapath. It generalises the two-input combinational join to NUM_INPUTS channels. Each channel has its own DEPTH-entry elastic FIFO, so upstream producers are decoupled from downstream back-pressure. One output token is emitted only when every enabled channel holds data. A per-channel enable mask replaces the old single "feedback" mode; disabled channels are never waited on and never accept data.

Parameters:
DATA_WIDTH, 32, width of each channel's data
NUM_INPUTS, 2, number of joined channels (>=2)
DEPTH, 2, entries per channel FIFO (power of two, >=2)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
din  input  NUM_INPUTS*DATA_WIDTH  packed channel data, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
din_v  input  NUM_INPUTS  per-channel valid
din_r  output  NUM_INPUTS  per-channel ready
dout  output  NUM_INPUTS*DATA_WIDTH  packed joined data, same lane mapping as din
dout_v  output  1  joined token valid
dout_r  input  1  downstream ready
cfg_enable  input  NUM_INPUTS  1 = channel participates in the join
cfg_flush  input  1  synchronous clear of all FIFOs
occupancy  output  NUM_INPUTS*$clog2(DEPTH+1)  per-channel entry count, channel i at [i*CW +: CW]

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n). On assertion, all FIFO pointers and counts clear immediately.
- Values held during and right after reset:
  - dout_v=0, occupancy=0, dout=0.
  - din_r = cfg_enable, because all FIFOs are empty.
- Per-channel FIFO, registered storage, no bypass:
  - din_r[i] = cfg_enable[i] && !full[i]. It depends only on local state, never on dout_r or other channels.
  - Push[i] = din_v[i] && din_r[i].
  - Data accepted at edge k is visible on dout no earlier than edge k+1 (minimum latency 1 cycle).
- Join:
  - head_v[i] = count[i]!=0.
  - dout_v = (|cfg_enable) && AND over i of (!cfg_enable[i] || head_v[i]).
  - If cfg_enable is all-zero, dout_v=0.
- Fire = dout_v && dout_r. On fire, every enabled channel pops its head in the same cycle. Disabled channels never pop.
- dout lane i = head of FIFO i when cfg_enable[i]=1, else all zeros. dout is stable while dout_v=1 and dout_r=0 (AXI-style hold).
- Simultaneous push and pop on the same channel: count is unchanged and both pointers advance.
  - A full channel cannot push, since din_r=0. A pop in that cycle frees a slot that is usable next cycle only (no ready-through path).
  - An empty channel cannot pop.
- Pointers wrap modulo DEPTH.
  - Count width is CW = $clog2(DEPTH+1).
  - full = (count==DEPTH); empty = (count==0).
- cfg_enable may change at any cycle.
  - A channel that becomes disabled keeps its stored entries: they are not popped and not shown on dout.
  - Re-enabling the channel resumes with those entries.
  - The change affects dout_v and din_r combinationally in the same cycle.
- cfg_flush=1 at a clock edge: all counts and pointers go to 0, and any push or pop in that cycle is discarded.
  - dout_v=0 in the following cycle.
  - din_r stays combinationally valid; pushes are ignored while flush is high.
- Reset mid-transfer drops all buffered tokens. No partial token is ever emitted; dout_v falls asynchronously.
- No combinational path from din_v to din_r, or from dout_r to din_r.

Test Plan:
1. NUM_INPUTS=3, DEPTH=2, cfg_enable=3'b111, all channels pushed 0x11/0x22/0x33 in cycle 0, dout_r=1 -> dout_v=1 in cycle 1 with lanes {0x33,0x22,0x11}; the token fires and all occupancy returns to 0 in cycle 2.
2. Skewed arrival, cfg_enable=3'b111, dout_r=1: ch0 at cycle 0, ch1 at cycle 3, ch2 at cycle 5 -> dout_v=0 until cycle 6, dout_v=1 in cycle 6; occupancy of ch0 is 1 during cycles 1..6.
3. Back-pressure: dout_r=0, continuous din_v=1 on all channels -> each din_r drops after DEPTH=2 accepts. dout holds the first token. Releasing dout_r=1 drains the tokens in order with no loss or duplication (check against a scoreboard).
4. cfg_enable=3'b001 (feedback-like) -> din_r[2:1]=0, and tokens flow on ch0 alone with lanes 1..2 zero. Enabling ch1 while ch1 is empty -> dout_v drops to 0 until ch1 receives data.
5. Two tokens buffered per channel, assert cfg_flush for one cycle with dout_r=1 -> no fire that cycle, occupancy=0 and dout_v=0 the next cycle.
6. Assert rst_n=0 mid-cycle while dout_v=1 -> dout_v and occupancy go to 0 before the next edge. After release, din_r equals cfg_enable.
